// File: rtl/pc_pkg.sv
// Shared encodings for the multi-context program counter: fetch-mode
// codes and the context-switch FSM states.
package pc_pkg;

  localparam logic [1:0] CTRL_SEQ  = 2'b00;
  localparam logic [1:0] CTRL_BOOT = 2'b01;
  localparam logic [1:0] CTRL_HOLD = 2'b10;
  localparam logic [1:0] CTRL_BR   = 2'b11;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    SALVA    = 2'd1,
    RESTAURA = 2'd2
  } estado_t;

endpackage

// File: rtl/pc_contexto_tabela.sv
// Saved-PC register file: one write port, one read port; a write to the
// index being read in the same cycle is forwarded straight to the read data.
module tabela_contexto #(
  parameter int               WIDTH     = 32,
  parameter int               N_CTX     = 4,
  parameter int               CTX_W     = $clog2(N_CTX),
  parameter logic [WIDTH-1:0] BOOT_ADDR = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [CTX_W-1:0] widx_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [CTX_W-1:0] ridx_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [N_CTX];

  // Storage: every entry returns to the boot vector on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CTX; i++) begin
        mem_q[i] <= BOOT_ADDR;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  // Read with write-through bypass.
  always_comb begin
    if (we_i && (widx_i == ridx_i)) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = mem_q[ridx_i];
    end
  end

endmodule

// File: rtl/pc_contexto.sv
// Registered fetch PC with N hardware contexts; context switches save the
// outgoing next PC, then restore the destination's saved PC two cycles later.
module pc_contexto
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_CTX     = 4,
  parameter int               CTX_W     = $clog2(N_CTX),
  parameter logic [WIDTH-1:0] BOOT_ADDR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INC       = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       controle,
  input  logic             branch,
  input  logic [WIDTH-1:0] endereco_branch,
  input  logic             pausa,
  input  logic             troca_req,
  input  logic [CTX_W-1:0] ctx_destino,
  output logic             troca_ok,
  output logic             ocupado,
  output logic [CTX_W-1:0] ctx_atual,
  input  logic             tab_escreve,
  input  logic [CTX_W-1:0] tab_indice,
  input  logic [WIDTH-1:0] tab_dado,
  output logic [WIDTH-1:0] endereco_saida
);

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] pc_q, pc_d, next_pc_s;
  logic [CTX_W-1:0] ctx_q, ctx_d, dest_q, dest_d;
  logic             salva_s;
  logic             tab_we_s;
  logic [CTX_W-1:0] tab_idx_s;
  logic [WIDTH-1:0] tab_wdata_s, tab_rdata_s;

  // Next fetch address; boot overrides a stall.
  always_comb begin
    if (controle == CTRL_BOOT) begin
      next_pc_s = BOOT_ADDR;
    end else if (pausa) begin
      next_pc_s = pc_q;
    end else if ((controle == CTRL_BR) && branch) begin
      next_pc_s = endereco_branch;
    end else if (controle == CTRL_HOLD) begin
      next_pc_s = pc_q;
    end else begin
      next_pc_s = pc_q + INC;
    end
  end

  assign salva_s = (estado_q == EXEC) && troca_req && !pausa;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= EXEC;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM next state.
  always_comb begin
    case (estado_q)
      EXEC:     estado_d = salva_s ? SALVA : EXEC;
      SALVA:    estado_d = RESTAURA;
      RESTAURA: estado_d = EXEC;
      default:  estado_d = EXEC;
    endcase
  end

  // FSM outputs.
  always_comb begin
    troca_ok = (estado_q == RESTAURA);
    ocupado  = (estado_q != EXEC);
  end

  // The save write owns the table port in its cycle, so it beats an
  // external write to the same entry.
  always_comb begin
    if (salva_s) begin
      tab_we_s    = 1'b1;
      tab_idx_s   = ctx_q;
      tab_wdata_s = next_pc_s;
    end else begin
      tab_we_s    = tab_escreve;
      tab_idx_s   = tab_indice;
      tab_wdata_s = tab_dado;
    end
  end

  // Datapath next state.
  always_comb begin
    pc_d   = pc_q;
    ctx_d  = ctx_q;
    dest_d = dest_q;
    case (estado_q)
      EXEC: begin
        if (salva_s) begin
          dest_d = ctx_destino;
        end else begin
          pc_d = next_pc_s;
        end
      end
      SALVA: begin
        pc_d = pc_q;
      end
      RESTAURA: begin
        pc_d  = tab_rdata_s;
        ctx_d = dest_q;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= BOOT_ADDR;
      ctx_q  <= {CTX_W{1'b0}};
      dest_q <= {CTX_W{1'b0}};
    end else begin
      pc_q   <= pc_d;
      ctx_q  <= ctx_d;
      dest_q <= dest_d;
    end
  end

  tabela_contexto #(
    .WIDTH     (WIDTH),
    .N_CTX     (N_CTX),
    .CTX_W     (CTX_W),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_tabela (
    .clock   (clock),
    .reset_n (reset_n),
    .we_i    (tab_we_s),
    .widx_i  (tab_idx_s),
    .wdata_i (tab_wdata_s),
    .ridx_i  (dest_q),
    .rdata_o (tab_rdata_s)
  );

  assign endereco_saida = pc_q;
  assign ctx_atual      = ctx_q;

endmodule

// File: tb/tb_pc_contexto.sv
// Scoreboard bench for pc_contexto: a behavioural model pushes the expected
// post-edge outputs each cycle; they are popped and compared after the edge.
module tb_pc_contexto;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  controle = 2'b00;
  logic        branch = 1'b0;
  logic [31:0] endereco_branch = 32'h0;
  logic        pausa = 1'b0;
  logic        troca_req = 1'b0;
  logic [1:0]  ctx_destino = 2'd0;
  logic        troca_ok, ocupado;
  logic [1:0]  ctx_atual;
  logic        tab_escreve = 1'b0;
  logic [1:0]  tab_indice = 2'd0;
  logic [31:0] tab_dado = 32'h0;
  logic [31:0] endereco_saida;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ctx;
    logic        ocup;
    logic        ok;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_pc;
  logic [1:0]  m_ctx, m_dest;
  int          m_state;
  logic [31:0] m_tab [4];

  pc_contexto dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .controle        (controle),
    .branch          (branch),
    .endereco_branch (endereco_branch),
    .pausa           (pausa),
    .troca_req       (troca_req),
    .ctx_destino     (ctx_destino),
    .troca_ok        (troca_ok),
    .ocupado         (ocupado),
    .ctx_atual       (ctx_atual),
    .tab_escreve     (tab_escreve),
    .tab_indice      (tab_indice),
    .tab_dado        (tab_dado),
    .endereco_saida  (endereco_saida)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ctx = 2'd0; m_dest = 2'd0; m_state = 0;
    for (int i = 0; i < 4; i++) m_tab[i] = 32'h0;
    sb_q.delete();
  endtask

  // One clock: model the edge, push expectation, then pop and compare.
  task automatic tick();
    exp_t e, g;
    logic [31:0] np;
    logic saving;
    saving = 1'b0;
    if (m_state == 0) begin
      if (controle == 2'b01) np = 32'h0;
      else if (pausa) np = m_pc;
      else if (controle == 2'b11 && branch) np = endereco_branch;
      else if (controle == 2'b10) np = m_pc;
      else np = m_pc + 32'd1;
      saving = troca_req && !pausa;
    end else begin
      np = m_pc;
    end
    if (tab_escreve && !saving) m_tab[tab_indice] = tab_dado;
    if (m_state == 0) begin
      if (saving) begin
        m_tab[m_ctx] = np; m_dest = ctx_destino; m_state = 1;
      end else begin
        m_pc = np;
      end
    end else if (m_state == 1) begin
      m_state = 2;
    end else begin
      m_pc = m_tab[m_dest]; m_ctx = m_dest; m_state = 0;
    end
    e.pc = m_pc; e.ctx = m_ctx; e.ocup = (m_state != 0); e.ok = (m_state == 2);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    g = sb_q.pop_front();
    check_eq("sb_pc", endereco_saida, g.pc);
    check_eq("sb_ctx", {30'd0, ctx_atual}, {30'd0, g.ctx});
    check_eq("sb_ocupado", {31'd0, ocupado}, {31'd0, g.ocup});
    check_eq("sb_troca_ok", {31'd0, troca_ok}, {31'd0, g.ok});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_pc", endereco_saida, 32'h0);
    check_eq("rst_ctx", {30'd0, ctx_atual}, 32'h0);
    check_eq("rst_ocupado", {31'd0, ocupado}, 32'h0);
    check_eq("rst_troca_ok", {31'd0, troca_ok}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drv(input logic [1:0] c, input logic b, input logic [31:0] tgt);
    controle = c; branch = b; endereco_branch = tgt;
  endtask

  // Full three-cycle switch; the request drops during RESTAURA.
  task automatic switch_to(input logic [1:0] dst);
    troca_req = 1'b1; ctx_destino = dst;
    tick();
    tick();
    troca_req = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();

    drv(2'b00, 1'b0, 32'h0);
    repeat (3) tick();
    check_eq("seq_pc3", endereco_saida, 32'h3);

    repeat (2) tick();
    drv(2'b11, 1'b1, 32'h100); tick();
    check_eq("branch_taken", endereco_saida, 32'h100);
    drv(2'b11, 1'b1, 32'h5); tick();
    drv(2'b11, 1'b0, 32'h100); tick();
    check_eq("branch_not_taken", endereco_saida, 32'h6);
    drv(2'b11, 1'b1, 32'h5); tick();
    drv(2'b10, 1'b0, 32'h0); tick();
    check_eq("hold", endereco_saida, 32'h5);

    drv(2'b11, 1'b1, 32'hFFFF_FFFF); tick();
    drv(2'b00, 1'b0, 32'h0); tick();
    check_eq("wrap", endereco_saida, 32'h0);
    tick();
    pausa = 1'b1; drv(2'b01, 1'b0, 32'h0); tick();
    check_eq("boot_over_pausa", endereco_saida, 32'h0);
    pausa = 1'b0;

    drv(2'b10, 1'b0, 32'h0);
    tab_escreve = 1'b1; tab_indice = 2'd2; tab_dado = 32'h400; tick();
    tab_escreve = 1'b0;
    drv(2'b11, 1'b1, 32'h10); tick();
    troca_req = 1'b1; ctx_destino = 2'd2; drv(2'b11, 1'b1, 32'h80);
    tick();
    check_eq("sw_ocupado1", {31'd0, ocupado}, 32'h1);
    check_eq("sw_pc_holds", endereco_saida, 32'h10);
    drv(2'b00, 1'b0, 32'h0); tick();
    check_eq("sw_troca_ok", {31'd0, troca_ok}, 32'h1);
    troca_req = 1'b0; tick();
    check_eq("sw_pc_restored", endereco_saida, 32'h400);
    check_eq("sw_ctx2", {30'd0, ctx_atual}, 32'h2);
    drv(2'b10, 1'b0, 32'h0);
    switch_to(2'd0);
    check_eq("sw_back_pc", endereco_saida, 32'h80);

    pausa = 1'b1; troca_req = 1'b1; ctx_destino = 2'd1; drv(2'b00, 1'b0, 32'h0);
    repeat (4) tick();
    check_eq("pausa_blocks", {31'd0, ocupado}, 32'h0);
    pausa = 1'b0; tick();
    check_eq("pausa_release", {31'd0, ocupado}, 32'h1);
    ctx_destino = 2'd3; tick();
    troca_req = 1'b0; tick();
    check_eq("ignored_req_ctx", {30'd0, ctx_atual}, 32'h1);

    troca_req = 1'b1; ctx_destino = 2'd3; drv(2'b10, 1'b0, 32'h0);
    tick(); tick();
    troca_req = 1'b0; tab_escreve = 1'b1; tab_indice = 2'd3; tab_dado = 32'h777;
    tick();
    tab_escreve = 1'b0;
    check_eq("bypass_pc", endereco_saida, 32'h777);

    tab_escreve = 1'b1; tab_indice = 2'd1; tab_dado = 32'h555; tick();
    tab_escreve = 1'b0;
    troca_req = 1'b1; ctx_destino = 2'd1; tick();
    troca_req = 1'b0;
    #2;
    do_reset();
    for (int i = 1; i < 4; i++) begin
      switch_to(i[1:0]);
      check_eq("post_rst_tab", endereco_saida, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
